// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MAR/MDR memory interface.
// Accepts level read/write requests, inserts WAIT_STATES wait cycles, performs
// the access on an internal word array and strobes mem_ready for one cycle.
// A release state holds off re-acceptance until both requests have dropped,
// so a level request held for several cycles is serviced exactly once.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-high reset
//   MAR_addr     in   word address
//   MDR_data_in  in   write data
//   MDR_read     in   read request (level)
//   RAM_write    in   write request (level), wins when both are high
//   mem_data_out out  last read data, held until the next read completes
//   mem_ready    out  one-cycle completion strobe
//   mem_busy     out  high from acceptance until the handshake is released
//   addr_err     out  with mem_ready: accepted address was out of range
//   collision    out  with mem_ready: both requests were high at acceptance
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] MAR_addr,
  input  logic [DATA_WIDTH-1:0] MDR_data_in,
  input  logic                  MDR_read,
  input  logic                  RAM_write,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  addr_err,
  output logic                  collision
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  req;
  logic                  accept;
  logic                  in_oor;

  // Request latched at acceptance; later input changes are ignored.
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic                  lat_wr;
  logic                  lat_oor;
  logic                  lat_col;

  // Effective transaction attributes: live inputs when accepting straight
  // into DONE (no wait states), latched copies otherwise.
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_wr;
  logic                  cur_oor;
  logic                  cur_col;
  logic                  enter_done;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State and wait counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic and transaction selection.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept     = 1'b0;
    req        = MDR_read | RAM_write;
    in_oor     = (32'(MAR_addr) >= DEPTH);
    cur_addr   = lat_addr;
    cur_wr     = lat_wr;
    cur_oor    = lat_oor;
    cur_col    = lat_col;
    enter_done = 1'b0;

    case (state)
      S_IDLE: begin
        cur_addr = MAR_addr;
        cur_wr   = RAM_write;
        cur_oor  = in_oor;
        cur_col  = MDR_read & RAM_write;
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = WAIT_LOAD;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_n = S_DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_RELEASE;
      end
      S_RELEASE: begin
        if (!req) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    enter_done = (state_n == S_DONE);
  end

  // Request latch and registered outputs; read data is captured on the edge
  // entering DONE so it is visible alongside mem_ready.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_wr       <= 1'b0;
      lat_oor      <= 1'b0;
      lat_col      <= 1'b0;
      mem_data_out <= '0;
      mem_ready    <= 1'b0;
      mem_busy     <= 1'b0;
      addr_err     <= 1'b0;
      collision    <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= MAR_addr;
        lat_data <= MDR_data_in;
        lat_wr   <= RAM_write;
        lat_oor  <= in_oor;
        lat_col  <= MDR_read & RAM_write;
      end
      mem_ready <= enter_done;
      mem_busy  <= (state_n != S_IDLE);
      addr_err  <= enter_done & cur_oor;
      collision <= enter_done & cur_col;
      if (enter_done && !cur_wr) begin
        mem_data_out <= cur_oor ? '0 : mem[IDX_W'(cur_addr)];
      end
    end
  end

  // Array write on the edge leaving DONE; out-of-range writes are dropped.
  // A reset before DONE returns the FSM to IDLE, abandoning the write.
  always_ff @(posedge Clock) begin
    if (state == S_DONE && lat_wr && !lat_oor) begin
      mem[IDX_W'(lat_addr)] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses DEPTH=256, WAIT_STATES=2;
// instance 1 uses DEPTH=512, WAIT_STATES=0. A word-array model tracks
// expected contents and the last read value per instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, rdq, wrq, rdy, busy, aerr, coll;
  logic [8:0]  mar  [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl     [2][512];
  bit          known   [2][512];
  logic [31:0] last_rd [2];

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u0 (
    .Clock(clk), .Reset(rst[0]), .MAR_addr(mar[0]), .MDR_data_in(din[0]),
    .MDR_read(rdq[0]), .RAM_write(wrq[0]), .mem_data_out(dout[0]),
    .mem_ready(rdy[0]), .mem_busy(busy[0]), .addr_err(aerr[0]), .collision(coll[0])
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512), .WAIT_STATES(0)) u1 (
    .Clock(clk), .Reset(rst[1]), .MAR_addr(mar[1]), .MDR_data_in(din[1]),
    .MDR_read(rdq[1]), .RAM_write(wrq[1]), .mem_data_out(dout[1]),
    .mem_ready(rdy[1]), .mem_busy(busy[1]), .addr_err(aerr[1]), .collision(coll[1])
  );

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int sel);
    return (sel == 0) ? 256 : 512;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: drive, accept, watch for the single ready
  // pulse, hold the request 'hold' samples after acceptance, then release.
  task automatic access(input int sel, input bit rd, input bit wr,
                        input logic [8:0] a, input logic [31:0] d,
                        input int hold, input bit scramble, input string tag);
    int ws, pulses, last_c;
    bit oor, col, is_w;
    logic [31:0] exp_dout;
    ws       = ws_of(sel);
    oor      = (int'(a) >= depth_of(sel));
    is_w     = wr;
    col      = rd && wr;
    exp_dout = is_w ? last_rd[sel] : (oor ? 32'h0 : mdl[sel][a]);
    mar[sel] = a;
    din[sel] = d;
    rdq[sel] = rd;
    wrq[sel] = wr;
    tick();
    pulses = 0;
    last_c = ((ws > hold) ? ws : hold) + 2;
    for (int c = 0; c <= last_c; c++) begin
      if (rdy[sel] === 1'b1) begin
        pulses++;
        total++;
        if (c != ws || aerr[sel] !== oor || coll[sel] !== col || dout[sel] !== exp_dout) begin
          bad++;
          $display("FAIL %s ready: cycle=%0d want %0d, addr_err=%b want %b, collision=%b want %b, data=%h want %h",
                   tag, c, ws, aerr[sel], oor, coll[sel], col, dout[sel], exp_dout);
        end
      end
      if (c < hold) begin
        total++;
        if (busy[sel] !== 1'b1) begin
          bad++;
          $display("FAIL %s busy_held: c=%0d got %b want 1", tag, c, busy[sel]);
        end
      end
      if (scramble) begin
        mar[sel] = 9'($urandom);
        din[sel] = $urandom;
      end
      if (c + 1 >= hold) begin
        rdq[sel] = 1'b0;
        wrq[sel] = 1'b0;
      end
      if (c < last_c) tick();
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL %s pulse_count: got %0d want 1", tag, pulses);
    end
    total++;
    if (busy[sel] !== 1'b0 || rdy[sel] !== 1'b0) begin
      bad++;
      $display("FAIL %s released: busy=%b ready=%b want 0 0", tag, busy[sel], rdy[sel]);
    end
    if (is_w && !oor) begin
      mdl[sel][a]   = d;
      known[sel][a] = 1'b1;
    end
    if (!is_w) last_rd[sel] = exp_dout;
  endtask

  task automatic check_zero(input int sel, input string tag);
    total++;
    if (dout[sel] !== 32'h0 || rdy[sel] !== 1'b0 || busy[sel] !== 1'b0 ||
        aerr[sel] !== 1'b0 || coll[sel] !== 1'b0) begin
      bad++;
      $display("FAIL %s: data=%h ready=%b busy=%b addr_err=%b collision=%b want all 0",
               tag, dout[sel], rdy[sel], busy[sel], aerr[sel], coll[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    rdq = 2'b00;
    wrq = 2'b00;
    for (int s = 0; s < 2; s++) begin
      mar[s] = '0;
      din[s] = '0;
      last_rd[s] = 32'h0;
      for (int i = 0; i < 512; i++) begin
        known[s][i] = 1'b0;
        mdl[s][i]   = 32'h0;
      end
    end
    #2;
    check_zero(0, "reset_u0");
    check_zero(1, "reset_u1");
    tick();
    tick();
    #3;
    rst = 2'b00;
    tick();
    check_zero(0, "post_reset_u0");
  endtask

  task automatic test_basic();
    access(0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1, 1'b0, "basic_write");
    access(0, 1'b1, 1'b0, 9'h005, 32'h0, 1, 1'b0, "basic_read");
  endtask

  task automatic test_held_read();
    access(0, 1'b0, 1'b1, 9'h010, 32'h12345678, 1, 1'b0, "held_preload");
    access(0, 1'b1, 1'b0, 9'h010, 32'h0, 10, 1'b0, "held_read");
  endtask

  task automatic test_addr_err();
    access(0, 1'b0, 1'b1, 9'h0FF, 32'hCAFEF00D, 1, 1'b0, "alias_preload");
    access(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1, 1'b0, "oor_read");
    access(0, 1'b0, 1'b1, 9'h1FF, 32'hAAAA5555, 1, 1'b0, "oor_write");
    access(0, 1'b1, 1'b0, 9'h0FF, 32'h0, 1, 1'b0, "alias_check");
  endtask

  task automatic test_collision();
    access(0, 1'b1, 1'b1, 9'h020, 32'h0000CAFE, 2, 1'b0, "collision_write");
    access(0, 1'b1, 1'b0, 9'h020, 32'h0, 1, 1'b0, "collision_read");
  endtask

  task automatic test_reset_mid_wait();
    access(0, 1'b0, 1'b1, 9'h030, 32'h11111111, 1, 1'b0, "rmw_preload");
    mar[0] = 9'h030;
    din[0] = 32'h55555555;
    wrq[0] = 1'b1;
    tick();
    total++;
    if (busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL rmw_busy: got %b want 1", busy[0]);
    end
    #2;
    rst[0] = 1'b1;
    #1;
    check_zero(0, "rmw_async_reset");
    last_rd[0] = 32'h0;
    wrq[0] = 1'b0;
    rdq[0] = 1'b1;
    tick();
    tick();
    #3;
    rst[0] = 1'b0;
    access(0, 1'b1, 1'b0, 9'h030, 32'h0, 1, 1'b0, "rmw_read_after_release");
  endtask

  task automatic test_zero_wait();
    access(1, 1'b0, 1'b1, 9'h1A5, 32'h0BADF00D, 1, 1'b0, "zw_write");
    access(1, 1'b0, 1'b1, 9'h1A6, 32'h600DCAFE, 1, 1'b0, "zw_write2");
    access(1, 1'b1, 1'b0, 9'h1A5, 32'h0, 3, 1'b1, "zw_read_scramble");
    access(1, 1'b1, 1'b0, 9'h1A6, 32'h0, 1, 1'b1, "zw_read_scramble2");
  endtask

  task automatic test_back_to_back();
    access(1, 1'b0, 1'b1, 9'h001, 32'h01010101, 1, 1'b0, "b2b_w1");
    access(1, 1'b1, 1'b0, 9'h001, 32'h0, 1, 1'b0, "b2b_r1");
    access(1, 1'b0, 1'b1, 9'h001, 32'h02020202, 1, 1'b0, "b2b_w2");
    access(1, 1'b1, 1'b0, 9'h001, 32'h0, 1, 1'b0, "b2b_r2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int sel, hold;
      logic [8:0] a;
      bit rd, wr, oor;
      sel  = n % 2;
      hold = int'($urandom_range(1, 6));
      a    = 9'($urandom);
      if ($urandom_range(0, 2) != 0 && n > 4) a = {1'b0, 8'($urandom_range(0, 15))};
      oor  = (int'(a) >= depth_of(sel));
      rd   = ($urandom_range(0, 1) == 1);
      if (rd && !oor && !known[sel][a]) rd = 1'b0;
      wr   = !rd || ($urandom_range(0, 7) == 0);
      access(sel, rd, wr, a, $urandom, hold, bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_read();
    test_addr_err();
    test_collision();
    test_reset_mid_wait();
    test_zero_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle datapath's MAR/MDR memory interface.
- Accepts read (MDR_read) and write (RAM_write) requests from the control unit, inserts a programmable number of wait states, and performs the access on an internal word array.
- Returns read data plus a one-cycle mem_ready completion strobe.
- A level-handshake guard ensures a request held for several states is serviced exactly once.

Parameters:
- ADDR_WIDTH, 9, width of MAR_addr (word address).
- DATA_WIDTH, 32, data word width.
- DEPTH, 512, number of implemented words; addresses >= DEPTH are out of range.
- WAIT_STATES, 2, extra cycles between acceptance and completion (0..15 legal).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- MAR_addr  input  ADDR_WIDTH  word address from MAR.
- MDR_data_in  input  DATA_WIDTH  write data from MDR.
- MDR_read  input  1  read request, level.
- RAM_write  input  1  write request, level.
- mem_data_out  output  DATA_WIDTH  read data to MDR; held until next read completes.
- mem_ready  output  1  one-cycle completion strobe.
- mem_busy  output  1  high from acceptance until the handshake is released.
- addr_err  output  1  pulses with mem_ready when the accepted address was out of range.
- collision  output  1  pulses with mem_ready when both requests were high at acceptance.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; wait counter cleared.
  - mem_data_out=0, mem_ready=0, mem_busy=0, addr_err=0, collision=0.
  - Memory array contents are NOT cleared.
  - An in-flight write that has not reached DONE is abandoned; its target word is unchanged.
- States: IDLE, WAIT, DONE, RELEASE.
- IDLE:
  - On a Clock edge with MDR_read|RAM_write=1, accept the request and latch MAR_addr, MDR_data_in and the operation.
  - If both requests are high, the operation is write and the collision flag is latched.
  - Next state is WAIT if WAIT_STATES>0, else DONE. mem_busy=1 from the next cycle.
- WAIT:
  - Counter loads WAIT_STATES-1 at acceptance and decrements each cycle.
  - At 0, go to DONE.
  - Request inputs are ignored here; the latched values are used.
- DONE (exactly one cycle):
  - mem_ready=1; addr_err and collision are driven from the latched flags.
  - Write: if address < DEPTH, the array word is updated at the edge leaving DONE.
  - Read: mem_data_out is updated with the array word, or 0 if out of range, and becomes visible in the DONE cycle. Use a registered read, not an asynchronous array read.
  - An out-of-range write is dropped.
  - Next state is RELEASE.
- RELEASE:
  - mem_busy stays 1.
  - Remain here while MDR_read|RAM_write=1; go to IDLE on the first edge where both are 0.
  - This prevents double service of a held level request.
- Latency: request accepted at edge k; mem_ready is high during cycle k+1+WAIT_STATES. With WAIT_STATES=0, mem_ready is high in the cycle after acceptance.
- Back-to-back: a new request needs at least one cycle with both requests low, so minimum spacing is WAIT_STATES+3 cycles.
- Read-after-write to the same address returns the new value.
- mem_data_out holds its last read value across writes, errors and idle periods.
- Address and data changing after acceptance have no effect.
- Reset asserted mid-WAIT, then released with a request still high: the request is accepted fresh on the first edge after release.

Test Plan:
- WAIT_STATES=2: write 0xDEADBEEF to address 0x005, deassert, then read 0x005 -> mem_ready exactly 3 cycles after each acceptance; read returns 0xDEADBEEF; addr_err=0 and collision=0.
- MDR_read held high for 10 cycles at address 0x010 (preloaded 0x12345678) -> exactly one mem_ready pulse; mem_busy stays 1 until MDR_read drops; mem_data_out=0x12345678.
- DEPTH=256: read at address 0x1FF -> mem_data_out=0, addr_err pulses with mem_ready. Write 0xAAAA5555 to 0x1FF -> array unchanged, addr_err pulses.
- MDR_read and RAM_write both high with address 0x020 and data 0x0000CAFE -> treated as write, collision=1 during mem_ready; a following read of 0x020 returns 0x0000CAFE.
- Write 0x11111111 to 0x030 first. Then write 0x55555555 to 0x030 and assert Reset asynchronously in the WAIT cycle -> all outputs 0 immediately; a later read of 0x030 returns 0x11111111.
- WAIT_STATES=0: read accepted at edge k -> mem_ready high in cycle k+1. Address/data changes after acceptance do not alter the access.
